// File: rtl/bgr_ctrl_pkg.sv
// Shared definitions for the bandgap start-up controller: FSM state encoding
// and default timing parameters.
package bgr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KICK,
        ST_SETTLE,
        ST_CHECK,
        ST_READY,
        ST_FAULT
    } bgr_state_e;

    localparam int unsigned DEF_KICK_CYCLES    = 4;
    localparam int unsigned DEF_SETTLE_CYCLES  = 8;
    localparam int unsigned DEF_OK_CYCLES      = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
    localparam int unsigned DEF_MAX_ATTEMPTS   = 2;

    function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bgr_sync2.sv
// Two-flop synchronizer for the asynchronous bandgap comparator output.
module bgr_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up controller: kicks the core, waits, qualifies vbg_ok and
// retries a bounded number of times before declaring a sticky fault.
module bgr_startup_ctrl
    import bgr_ctrl_pkg::*;
#(
    parameter int unsigned KICK_CYCLES    = DEF_KICK_CYCLES,
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned OK_CYCLES      = DEF_OK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic                                vbg_ok,
    output logic                                porst,
    output logic                                bgr_ready,
    output logic                                fault,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempt_cnt
);

    localparam int unsigned CW = $clog2(max_of4(KICK_CYCLES, SETTLE_CYCLES,
                                                OK_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam int unsigned AW = $clog2(MAX_ATTEMPTS+1);

    localparam logic [CW-1:0] KICK_LAST    = CW'(KICK_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] OK_LAST      = CW'(OK_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] ATT_MAX      = AW'(MAX_ATTEMPTS);
    localparam logic [AW-1:0] ATT_ONE      = AW'(1);

    bgr_state_e      state, state_nx;
    logic [CW-1:0]   tcnt, tcnt_nx, tcnt_inc;
    logic [CW-1:0]   okcnt, okcnt_nx, okcnt_inc;
    logic [AW-1:0]   att_nx, att_inc;
    logic            ok_s;

    bgr_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (vbg_ok),
        .q   (ok_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tcnt        <= '0;
            okcnt       <= '0;
            attempt_cnt <= '0;
            porst       <= 1'b0;
            bgr_ready   <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nx;
            tcnt        <= tcnt_nx;
            okcnt       <= okcnt_nx;
            attempt_cnt <= att_nx;
            // Flags decode the current state, so they trail it by one edge.
            porst       <= (state == ST_KICK);
            bgr_ready   <= (state == ST_READY);
            fault       <= (state == ST_FAULT);
        end
    end

    always_comb begin
        tcnt_inc  = (tcnt == '1) ? tcnt : tcnt + 1'b1;
        okcnt_inc = (okcnt == '1) ? okcnt : okcnt + 1'b1;
        att_inc   = (attempt_cnt == '1) ? attempt_cnt : attempt_cnt + 1'b1;

        state_nx = state;
        tcnt_nx  = tcnt;
        okcnt_nx = okcnt;
        att_nx   = attempt_cnt;

        if (!enable) begin
            state_nx = ST_IDLE;
            tcnt_nx  = '0;
            okcnt_nx = '0;
            att_nx   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_nx = ST_KICK;
                    tcnt_nx  = '0;
                    okcnt_nx = '0;
                    att_nx   = ATT_ONE;
                end
                ST_KICK: begin
                    if (tcnt >= KICK_LAST) begin
                        state_nx = ST_SETTLE;
                        tcnt_nx  = '0;
                    end else begin
                        tcnt_nx = tcnt_inc;
                    end
                end
                ST_SETTLE: begin
                    if (tcnt >= SETTLE_LAST) begin
                        state_nx = ST_CHECK;
                        tcnt_nx  = '0;
                        okcnt_nx = '0;
                    end else begin
                        tcnt_nx = tcnt_inc;
                    end
                end
                ST_CHECK: begin
                    // Success is tested before timeout so a tie resolves to READY.
                    if (ok_s && okcnt >= OK_LAST) begin
                        state_nx = ST_READY;
                        tcnt_nx  = '0;
                        okcnt_nx = '0;
                        att_nx   = '0;
                    end else if (tcnt >= TIMEOUT_LAST) begin
                        tcnt_nx  = '0;
                        okcnt_nx = '0;
                        if (attempt_cnt < ATT_MAX) begin
                            state_nx = ST_KICK;
                            att_nx   = att_inc;
                        end else begin
                            state_nx = ST_FAULT;
                        end
                    end else begin
                        tcnt_nx  = tcnt_inc;
                        okcnt_nx = ok_s ? okcnt_inc : '0;
                    end
                end
                ST_READY: begin
                    // okcnt here counts consecutive low samples.
                    if (ok_s) begin
                        okcnt_nx = '0;
                    end else if (okcnt >= OK_LAST) begin
                        state_nx = ST_KICK;
                        tcnt_nx  = '0;
                        okcnt_nx = '0;
                        att_nx   = ATT_ONE;
                    end else begin
                        okcnt_nx = okcnt_inc;
                    end
                end
                ST_FAULT: begin
                    state_nx = ST_FAULT;
                end
                default: begin
                    state_nx = ST_IDLE;
                    tcnt_nx  = '0;
                    okcnt_nx = '0;
                    att_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Directed self-checking bench for bgr_startup_ctrl with default parameters.
module tb_bgr_startup_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       vbg_ok;
    logic       porst;
    logic       bgr_ready;
    logic       fault;
    logic [1:0] attempt_cnt;

    int unsigned n_cmp;
    int unsigned n_bad;

    bgr_startup_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .vbg_ok      (vbg_ok),
        .porst       (porst),
        .bgr_ready   (bgr_ready),
        .fault       (fault),
        .attempt_cnt (attempt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        enable = 1'b0;
        tick();
        tick();
    endtask

    // Fresh start with vbg_ok steady high; edge 0 is the first tick after enable.
    task automatic good_sequence(input string tag);
        enable = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            tick();
            chk({tag, ".porst"}, 32'(porst), 32'(e >= 1 && e <= 4));
            chk({tag, ".ready"}, 32'(bgr_ready), 32'(e >= 16));
            if (e == 0)  chk({tag, ".att0"}, 32'(attempt_cnt), 32'd1);
            if (e == 16) chk({tag, ".att16"}, 32'(attempt_cnt), 32'd0);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b0;
        enable = 1'b0;
        vbg_ok = 1'b0;
        #2 rst = 1'b1;
        #2;
        chk("rst.porst", 32'(porst), 32'd0);
        chk("rst.ready", 32'(bgr_ready), 32'd0);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.att", 32'(attempt_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        vbg_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle.porst", 32'(porst), 32'd0);
        end

        // vbg_ok held high: single kick, ready from edge 16
        good_sequence("good");

        // Short 2-cycle dropout in READY is ignored
        vbg_ok = 1'b0;
        tick();
        tick();
        vbg_ok = 1'b1;
        for (int k = 3; k <= 10; k++) begin
            tick();
            chk("drop2.ready", 32'(bgr_ready), 32'd1);
            chk("drop2.porst", 32'(porst), 32'd0);
        end

        // 5-cycle dropout: re-kick, then recover to READY
        vbg_ok = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 5) vbg_ok = 1'b1;
            chk("drop5.ready", 32'(bgr_ready), 32'(k <= 5 || k >= 21));
            chk("drop5.porst", 32'(porst), 32'(k >= 6 && k <= 9));
            if (k == 6) chk("drop5.att", 32'(attempt_cnt), 32'd1);
        end

        // vbg_ok held low: two kicks then sticky fault
        go_idle();
        vbg_ok = 1'b0;
        tick();
        tick();
        tick();
        enable = 1'b1;
        for (int e = 0; e <= 62; e++) begin
            tick();
            chk("bad.porst", 32'(porst), 32'((e >= 1 && e <= 4) || (e >= 29 && e <= 32)));
            chk("bad.fault", 32'(fault), 32'(e >= 57));
            chk("bad.ready", 32'(bgr_ready), 32'd0);
            if (e == 1)  chk("bad.att1", 32'(attempt_cnt), 32'd1);
            if (e == 30) chk("bad.att2", 32'(attempt_cnt), 32'd2);
        end
        enable = 1'b0;
        tick();
        chk("bad.att_clr", 32'(attempt_cnt), 32'd0);
        tick();
        chk("bad.fault_clr", 32'(fault), 32'd0);

        // Single low sample in CHECK restarts the good count
        tick();
        enable = 1'b1;
        for (int e = 0; e <= 22; e++) begin
            tick();
            if (e == 10) vbg_ok = 1'b1;
            if (e == 12) vbg_ok = 1'b0;
            if (e == 13) vbg_ok = 1'b1;
            chk("glitch.ready", 32'(bgr_ready), 32'(e >= 19));
        end

        // enable dropped during KICK, then fresh sequence
        go_idle();
        enable = 1'b1;
        tick();
        tick();
        chk("abort.porst1", 32'(porst), 32'd1);
        enable = 1'b0;
        tick();
        chk("abort.att2", 32'(attempt_cnt), 32'd0);
        tick();
        chk("abort.porst3", 32'(porst), 32'd0);
        tick();
        chk("abort.idle", 32'(porst), 32'd0);
        good_sequence("reen");

        // Async reset during KICK kills porst immediately
        go_idle();
        enable = 1'b1;
        tick();
        tick();
        tick();
        chk("rstk.pre", 32'(porst), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstk.porst", 32'(porst), 32'd0);
        chk("rstk.att", 32'(attempt_cnt), 32'd0);
        rst = 1'b0;
        go_idle();

        // Async reset mid-SETTLE, restart from KICK on release
        enable = 1'b1;
        for (int e = 0; e <= 6; e++) tick();
        chk("rsts.pre_att", 32'(attempt_cnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rsts.porst", 32'(porst), 32'd0);
        chk("rsts.ready", 32'(bgr_ready), 32'd0);
        chk("rsts.fault", 32'(fault), 32'd0);
        chk("rsts.att", 32'(attempt_cnt), 32'd0);
        #1 rst = 1'b0;
        good_sequence("rsts");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bgr_startup_ctrl.md
BGR_STARTUP_CTRL -- requirements
Module: bgr_startup_ctrl

Interface
REQ-001 Parameters: KICK_CYCLES, default 4, porst pulse length in clocks.
REQ-002 Parameters: SETTLE_CYCLES, default 8, wait after kick before checking.
REQ-003 Parameters: OK_CYCLES, default 3, consecutive synced vbg_ok samples needed to declare good or bad.
REQ-004 Parameters: TIMEOUT_CYCLES, default 16, maximum CHECK duration per attempt.
REQ-005 Parameters: MAX_ATTEMPTS, default 2, kick attempts before FAULT.
REQ-006 Ports: clk, input, 1, sole clock.
REQ-007 Ports: rst, input, 1, asynchronous active-high reset.
REQ-008 Ports: enable, input, 1, start-up request; low forces IDLE.
REQ-009 Ports: vbg_ok, input, 1, asynchronous bandgap-valid comparator output.
REQ-010 Ports: porst, output, 1, start-up kick to the bandgap core pull-down device.
REQ-011 Ports: bgr_ready, output, 1, reference valid.
REQ-012 Ports: fault, output, 1, start-up failed, sticky.
REQ-013 Ports: attempt_cnt, output, $clog2(MAX_ATTEMPTS+1), kicks issued in the current start-up.

Function
REQ-014 vbg_ok SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synced value ok_s only.
REQ-015 States SHALL be IDLE, KICK, SETTLE, CHECK, READY, FAULT; all outputs SHALL be registered and decoded from state: porst=1 only in KICK, bgr_ready=1 only in READY, fault=1 only in FAULT.
REQ-016 IDLE: enable=1 at an edge SHALL move to KICK on that edge, attempt_cnt<=1.
REQ-017 KICK SHALL last exactly KICK_CYCLES cycles, then go to SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-019 CHECK: the consecutive-high counter SHALL clear on any ok_s=0. Reaching OK_CYCLES SHALL move to READY and clear attempt_cnt.
REQ-020 CHECK: after TIMEOUT_CYCLES without success, if attempt_cnt<MAX_ATTEMPTS the block SHALL go to KICK and increment attempt_cnt; otherwise it SHALL go to FAULT.
REQ-021 If success and timeout fall on the same cycle, success SHALL win.
REQ-022 READY: OK_CYCLES consecutive ok_s=0 samples SHALL move to KICK with attempt_cnt<=1. Shorter low runs SHALL be ignored.
REQ-023 FAULT SHALL hold until enable=0.
REQ-024 enable=0 in any state SHALL move to IDLE on the next edge and clear all counters. This takes priority over every other transition.
REQ-025 All counters SHALL saturate and never wrap; widths SHALL be $clog2 of the largest parameter plus 1.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force: state IDLE, porst=0, bgr_ready=0, fault=0, attempt_cnt=0, synchronizer flops 0, all counters 0.
REQ-027 On rst deassertion the block SHALL stay in IDLE until enable is sampled high. Reset mid-operation SHALL abandon the sequence with no residual pulse.

Structure
REQ-028 Package bgr_ctrl_pkg SHALL hold the state enum and the default parameter constants.
REQ-029 The synchronizer SHALL be sub-module bgr_sync2 (d, q, clk, rst). All other logic SHALL be a single FSM-plus-counter module.

Verification (defaults; enable first sampled high at edge 0)
REQ-030 Hold vbg_ok=1 -> porst=1 at edges 1-4; bgr_ready=1 from edge 16; attempt_cnt=0 after edge 16.
REQ-031 Hold vbg_ok=0 -> two porst pulses (edges 1-4 and 29-32); fault=1 from edge 57; bgr_ready never 1.
REQ-032 In READY, drop vbg_ok for 2 cycles -> bgr_ready stays 1. Drop it for 5 cycles -> bgr_ready=0 and porst=1 within OK_CYCLES+3 edges of the drop.
REQ-033 In CHECK, a single-cycle vbg_ok low after 2 good samples -> count restarts; READY is reached 3 synced-good cycles later.
REQ-034 enable=0 during KICK at edge 2 -> porst=0 at edge 3 and state IDLE. Re-enable -> full fresh sequence with attempt_cnt=1.
REQ-035 rst pulse mid-SETTLE (between edges) -> all outputs 0 before the next edge. After release with enable=1, the sequence restarts from KICK.
